dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-organised data memory responder with programmable wait states and a one-cycle ready pulse.
// Optional macro DMEM_RESP_ERR_EN: flag out-of-range accesses with dmem_err instead of wrapping the index.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_req,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic        dmem_we,
  input  logic [3:0]  dmem_be,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [29:0]        widx_q;
  logic [31:0]        wdata_q;
  logic               we_q;
  logic [3:0]         be_q;

  logic               capture, access;
  logic [29:0]        acc_widx;
  logic [31:0]        acc_wdata;
  logic               acc_we;
  logic [3:0]         acc_be;
  logic               in_range, mem_en, wr_en, rd_en, err_d;
  logic [IDX_W-1:0]   acc_idx;

  logic [31:0]        mem [DEPTH_WORDS];
  logic [31:0]        rdata_q;
  logic               ready_q, err_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (dmem_req) state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt_q == CNT_W'(1)) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Access strobes; with no wait states the access uses the live inputs on the capture edge
  always_comb begin
    capture   = 1'b0;
    access    = 1'b0;
    acc_widx  = widx_q;
    acc_wdata = wdata_q;
    acc_we    = we_q;
    acc_be    = be_q;
    case (state_q)
      S_IDLE: begin
        capture   = dmem_req;
        access    = dmem_req && (WAIT_STATES == 0);
        acc_widx  = dmem_addr[31:2];
        acc_wdata = dmem_wdata;
        acc_we    = dmem_we;
        acc_be    = dmem_be;
      end
      S_WAIT:  access = (cnt_q == CNT_W'(1));
      default: access = 1'b0;
    endcase
  end

  assign in_range = (acc_widx < 30'(DEPTH_WORDS));
  assign acc_idx  = acc_widx[IDX_W-1:0];

`ifdef DMEM_RESP_ERR_EN
  assign mem_en = access && in_range;
  assign err_d  = access && !in_range;
`else
  assign mem_en = access;
  assign err_d  = 1'b0;
`endif

  assign wr_en = mem_en && acc_we;
  assign rd_en = mem_en && !acc_we;

  logic unused_ok;
  assign unused_ok = &{1'b0, dmem_addr[1:0], in_range};

  // Request capture, wait counter and registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (capture) begin
        cnt_q   <= CNT_W'(WAIT_STATES);
        widx_q  <= dmem_addr[31:2];
        wdata_q <= dmem_wdata;
        we_q    <= dmem_we;
        be_q    <= dmem_be;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      ready_q <= access;
      rdata_q <= rd_en ? mem[acc_idx] : 32'h0;
      err_q   <= err_d;
    end
  end

  // Array has no reset; lanes with be=0 keep their contents
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign dmem_ready = ready_q;
  assign dmem_rdata = rdata_q;
  assign dmem_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_STATES 1, 0, 3) driven by directed tables,
// hand-written corner sequences and random traffic checked against a byte-lane memory model.
module tb_dmem_responder;

  localparam int NI    = 3;
  localparam int DEPTH = 1024;
`ifdef DMEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic        we    [NI];
  logic [3:0]  be    [NI];
  logic [31:0] rdata [NI];
  logic        ready [NI];
  logic        err   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_STATES((g == 0) ? 1 : (g == 1) ? 0 : 3)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .dmem_req  (req[g]),
      .dmem_addr (addr[g]),
      .dmem_wdata(wdata[g]),
      .dmem_we   (we[g]),
      .dmem_be   (be[g]),
      .dmem_rdata(rdata[g]),
      .dmem_ready(ready[g]),
      .dmem_err  (err[g])
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference model: per-instance word array with per-byte "written" flags
  logic [31:0] mm [NI][DEPTH];
  logic [3:0]  kb [NI][DEPTH];

  task automatic model_access(input int k, input logic w, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] b,
                              output logic [31:0] er, output logic ee, output logic ek);
    int unsigned widx;
    int unsigned i;
    widx = a >> 2;
    er = 32'h0; ee = 1'b0; ek = 1'b1;
    if (ERR_EN && widx >= DEPTH) begin
      ee = 1'b1;
      return;
    end
    i = widx % DEPTH;
    if (w) begin
      for (int l = 0; l < 4; l++) begin
        if (b[l]) begin
          mm[k][i][8*l +: 8] = wd[8*l +: 8];
          kb[k][i][l] = 1'b1;
        end
      end
    end else begin
      er = mm[k][i];
      ek = (kb[k][i] == 4'hF);
    end
  endtask

  // One transaction; inputs are scrambled while waiting so only captured values may matter
  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] b, output logic [31:0] r, output logic e, output int lat);
    @(posedge clk); #1;
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = wd; be[k] = b;
    lat = 0; r = 32'h0; e = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ready[k]) begin
        lat = n; r = rdata[k]; e = err[k];
        break;
      end
      addr[k] = $urandom; wdata[k] = $urandom; we[k] = 1'($urandom); be[k] = 4'($urandom);
    end
    req[k] = 1'b0;
    @(posedge clk); #1;
    chk("pulse_drop", 64'({ready[k], err[k], rdata[k]}), 64'h0);
  endtask

  task automatic run(input int k, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] b);
    logic [31:0] r, er;
    logic        e, ee, ek;
    int          lat;
    model_access(k, w, a, wd, b, er, ee, ek);
    txn(k, w, a, wd, b, r, e, lat);
    chk("latency", 64'(lat), 64'(ws_of(k) + 1));
    chk("err", 64'(e), 64'(ee));
    if (ek) chk("rdata", 64'(r), 64'(er));
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  b;
    logic [31:0] exp_r;
    logic        exp_e;
  } vec_t;

  vec_t tab [12];

  initial begin
    logic [31:0] r, er;
    logic        e, ee, ek;
    int          lat;

    for (int k = 0; k < NI; k++) begin
      req[k] = 1'b0; addr[k] = '0; wdata[k] = '0; we[k] = 1'b0; be[k] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        mm[k][i] = '0; kb[k][i] = '0;
      end
    end

    tab[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
    tab[1]  = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    tab[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0, 1'b0};
    tab[3]  = '{1'b1, 32'h20,   32'h00AA0000, 4'b0100, 32'h0, 1'b0};
    tab[4]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11AA3344, 1'b0};
    tab[5]  = '{1'b1, 32'h20,   32'hFFFFFFFF, 4'h0, 32'h0, 1'b0};
    tab[6]  = '{1'b0, 32'h20,   32'h0,        4'hF, 32'h11AA3344, 1'b0};
    tab[7]  = '{1'b1, 32'h0,    32'h0BADF00D, 4'hF, 32'h0, 1'b0};
    tab[8]  = '{1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0, ERR_EN};
    tab[9]  = '{1'b0, 32'h1000, 32'h0, 4'hF, ERR_EN ? 32'h0 : 32'hCAFEF00D, ERR_EN};
    tab[10] = '{1'b0, 32'h0,    32'h0, 4'hF, ERR_EN ? 32'h0BADF00D : 32'hCAFEF00D, 1'b0};
    tab[11] = '{1'b0, 32'h13,   32'h0, 4'h0, 32'hDEADBEEF, 1'b0};

    // Power-on reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) chk("reset_outputs", 64'({ready[k], err[k], rdata[k]}), 64'h0);
    rst = 1'b0;

    // Directed table on the WAIT_STATES=1 instance
    for (int t = 0; t < 12; t++) begin
      model_access(0, tab[t].w, tab[t].a, tab[t].wd, tab[t].b, er, ee, ek);
      txn(0, tab[t].w, tab[t].a, tab[t].wd, tab[t].b, r, e, lat);
      chk($sformatf("tab%0d_latency", t), 64'(lat), 64'd2);
      chk($sformatf("tab%0d_rdata", t), 64'(r), 64'(tab[t].exp_r));
      chk($sformatf("tab%0d_err", t), 64'(e), 64'(tab[t].exp_e));
    end

    // Mid-sim reset then idle
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) chk("idle_quiet", 64'({ready[k], err[k], rdata[k]}), 64'h0);
    end

    // Back-to-back with req held high, WAIT_STATES=0
    begin
      logic        bw [4];
      logic [31:0] ba [4];
      logic [31:0] bd [4];
      int          idx;
      bw[0] = 1'b1; ba[0] = 32'h100; bd[0] = 32'hAAAA5555;
      bw[1] = 1'b1; ba[1] = 32'h104; bd[1] = 32'h12345678;
      bw[2] = 1'b0; ba[2] = 32'h100; bd[2] = 32'h0;
      bw[3] = 1'b0; ba[3] = 32'h104; bd[3] = 32'h0;
      idx = 0;
      @(posedge clk); #1;
      req[1] = 1'b1; we[1] = bw[0]; addr[1] = ba[0]; wdata[1] = bd[0]; be[1] = 4'hF;
      for (int n = 1; n <= 8; n++) begin
        @(posedge clk); #1;
        chk($sformatf("b2b_ready_c%0d", n), 64'(ready[1]), 64'((n % 2) == 1));
        if (ready[1] && idx < 4) begin
          model_access(1, bw[idx], ba[idx], bd[idx], 4'hF, er, ee, ek);
          if (ek) chk($sformatf("b2b_rdata%0d", idx), 64'(rdata[1]), 64'(er));
          idx++;
          if (idx < 4) begin
            we[1] = bw[idx]; addr[1] = ba[idx]; wdata[1] = bd[idx];
          end else begin
            req[1] = 1'b0;
          end
        end
      end
      req[1] = 1'b0;
      chk("b2b_count", 64'(idx), 64'd4);
    end

    // Reset while a write waits, WAIT_STATES=3
    run(2, 1'b1, 32'h40, 32'h12345678, 4'hF);
    @(posedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'hFFFFFFFF; be[2] = 4'hF;
    @(posedge clk); #1;
    chk("abort_wait0", 64'(ready[2]), 64'h0);
    @(posedge clk); #1;
    chk("abort_wait1", 64'(ready[2]), 64'h0);
    rst = 1'b1; req[2] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("abort_no_ready", 64'({ready[2], err[2], rdata[2]}), 64'h0);
    end
    rst = 1'b0;
    run(2, 1'b0, 32'h40, 32'h0, 4'hF);

    // Random traffic against the model, every instance
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 8; i++) run(k, 1'b1, 32'(i * 4), $urandom, 4'hF);
      for (int i = 0; i < 30; i++) begin
        logic [31:0] a;
        a = (($urandom_range(0, 4) == 0) ? 32'h1000 : 32'h0)
            + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
        run(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
